// File: rtl/frame_stream_writer.sv
// frame_stream_writer: unpacks a 1-bpp byte stream into per-pixel RAM writes,
// filling a back bank while the display reads disp_bank, and swapping banks
// only on a vsync_tick that follows a completely written frame.
module frame_stream_writer #(
   parameter int unsigned WIDTH     = 200,
   parameter int unsigned HEIGHT    = 150,
   parameter int unsigned NUM_BANKS = 16,
   parameter int unsigned X_ADDRW   = $clog2(WIDTH),
   parameter int unsigned Y_ADDRW   = $clog2(HEIGHT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         s_data,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic               vsync_tick,
   output logic [X_ADDRW-1:0] x_pos,
   output logic [Y_ADDRW-1:0] y_pos,
   output logic               data_in,
   output logic               we,
   output logic [3:0]         bank_counter,
   output logic [3:0]         disp_bank,
   output logic               frame_done
);

   localparam logic [X_ADDRW-1:0] X_LAST    = X_ADDRW'(WIDTH - 1);
   localparam logic [Y_ADDRW-1:0] Y_LAST    = Y_ADDRW'(HEIGHT - 1);
   localparam logic [3:0]         BANK_LAST = 4'(NUM_BANKS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_SWAP} state_t;

   state_t             state, state_nxt;
   logic [7:0]         shreg, shreg_nxt;
   logic [2:0]         bit_cnt, bit_cnt_nxt;
   logic [X_ADDRW-1:0] nx, nx_nxt;       // column of the next pixel to write
   logic [Y_ADDRW-1:0] ny, ny_nxt;       // row of the next pixel to write
   logic               last_pix, last_nxt; // final pixel of the frame is on the outputs
   logic [X_ADDRW-1:0] x_nxt;
   logic [Y_ADDRW-1:0] y_nxt;
   logic               data_nxt, we_nxt, ready_nxt, fd_nxt;
   logic [3:0]         bank_nxt, disp_nxt;
   logic               load, emit, pix, last_hit;

   // State and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         shreg        <= 8'd0;
         bit_cnt      <= 3'd0;
         nx           <= '0;
         ny           <= '0;
         last_pix     <= 1'b0;
         x_pos        <= '0;
         y_pos        <= '0;
         data_in      <= 1'b0;
         we           <= 1'b0;
         s_ready      <= 1'b0;
         frame_done   <= 1'b0;
         bank_counter <= 4'd1;
         disp_bank    <= 4'd0;
      end else begin
         state        <= state_nxt;
         shreg        <= shreg_nxt;
         bit_cnt      <= bit_cnt_nxt;
         nx           <= nx_nxt;
         ny           <= ny_nxt;
         last_pix     <= last_nxt;
         x_pos        <= x_nxt;
         y_pos        <= y_nxt;
         data_in      <= data_nxt;
         we           <= we_nxt;
         s_ready      <= ready_nxt;
         frame_done   <= fd_nxt;
         bank_counter <= bank_nxt;
         disp_bank    <= disp_nxt;
      end
   end

   // Next-state, pixel emission, raster advance and bank swap
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      nx_nxt      = nx;
      ny_nxt      = ny;
      last_nxt    = 1'b0;
      x_nxt       = x_pos;
      y_nxt       = y_pos;
      data_nxt    = data_in;
      we_nxt      = 1'b0;
      ready_nxt   = 1'b0;
      fd_nxt      = 1'b0;
      bank_nxt    = bank_counter;
      disp_nxt    = disp_bank;
      load        = 1'b0;
      emit        = 1'b0;
      pix         = 1'b0;
      last_hit    = 1'b0;

      case (state)
         IDLE: begin
            if (s_valid && s_ready) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end else begin
               ready_nxt = 1'b1;
            end
         end
         SHIFT: begin
            if (last_pix) begin
               // leftover bits of the final byte are dropped here
               state_nxt = WAIT_SWAP;
            end else if (bit_cnt != 3'd0) begin
               emit        = 1'b1;
               pix         = shreg[7];
               shreg_nxt   = {shreg[6:0], 1'b0};
               bit_cnt_nxt = bit_cnt - 3'd1;
            end else if (s_valid && s_ready) begin
               load = 1'b1;
            end else begin
               state_nxt = IDLE;
               ready_nxt = 1'b1;
            end
         end
         WAIT_SWAP: begin
            if (vsync_tick) begin
               disp_nxt  = bank_counter;
               bank_nxt  = (bank_counter == BANK_LAST) ? 4'd0 : bank_counter + 4'd1;
               fd_nxt    = 1'b1;
               x_nxt     = '0;
               y_nxt     = '0;
               nx_nxt    = '0;
               ny_nxt    = '0;
               ready_nxt = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (load) begin
         emit        = 1'b1;
         pix         = s_data[7];
         shreg_nxt   = {s_data[6:0], 1'b0};
         bit_cnt_nxt = 3'd7;
      end

      if (emit) begin
         last_hit = (nx == X_LAST) && (ny == Y_LAST);
         we_nxt   = 1'b1;
         data_nxt = pix;
         x_nxt    = nx;
         y_nxt    = ny;
         last_nxt = last_hit;
         if (nx == X_LAST) begin
            nx_nxt = '0;
            ny_nxt = (ny == Y_LAST) ? '0 : ny + Y_ADDRW'(1);
         end else begin
            nx_nxt = nx + X_ADDRW'(1);
         end
         // offer the next byte while the last bit is on the outputs
         ready_nxt = (bit_cnt_nxt == 3'd0) && !last_hit;
      end
   end

endmodule

// File: tb/tb_frame_stream_writer.sv
// Bench for frame_stream_writer: random byte streams checked against a
// pixel-queue / bank model derived from the raster and swap rules.
module tb_frame_stream_writer;

   localparam int unsigned W    = 202;
   localparam int unsigned H    = 3;
   localparam int unsigned NB   = 16;
   localparam int unsigned XW   = $clog2(W);
   localparam int unsigned YW   = $clog2(H);
   localparam int unsigned NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_ready;
   logic          vsync_tick;
   logic [XW-1:0] x_pos;
   logic [YW-1:0] y_pos;
   logic          data_in;
   logic          we;
   logic [3:0]    bank_counter;
   logic [3:0]    disp_bank;
   logic          frame_done;

   frame_stream_writer #(.WIDTH(W), .HEIGHT(H), .NUM_BANKS(NB)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .vsync_tick(vsync_tick), .x_pos(x_pos), .y_pos(y_pos), .data_in(data_in), .we(we),
      .bank_counter(bank_counter), .disp_bank(disp_bank), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: queue of pixels still owed, frame pixel count, banks
   typedef struct { int x; int y; logic v; bit last; } pix_t;
   pix_t q[$];
   int   pix_count = 0;
   int   m_bank = 1;
   int   m_disp = 0;
   bit   armed = 0;
   bit   swap_pend = 0;
   bit   track = 0;
   int   we_cnt = 0;
   int   first_cyc = 0;
   int   last_cyc = 0;
   int   cyc = 0;

   // Observe on the falling edge; the model advances with what it sees
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         q.delete();
         pix_count = 0;
         m_bank    = 1;
         m_disp    = 0;
         armed     = 0;
         swap_pend = 0;
      end else begin
         if (swap_pend) begin
            chk("frame_done_pulse", frame_done, 1);
            chk("swap_x", x_pos, 0);
            chk("swap_y", y_pos, 0);
            m_disp    = m_bank;
            m_bank    = (m_bank + 1) % NB;
            swap_pend = 0;
            armed     = 0;
            pix_count = 0;
         end else begin
            chk("frame_done_quiet", frame_done, 0);
         end
         chk("bank_counter", bank_counter, m_bank);
         chk("disp_bank", disp_bank, m_disp);
         chk("bank_ne_disp", bank_counter != disp_bank, 1);
         if (armed) chk("ready_while_waiting", s_ready, 0);
         if (armed && vsync_tick) swap_pend = 1;
         if (we) begin
            if (track) begin
               if (we_cnt == 0) first_cyc = cyc;
               last_cyc = cyc;
               we_cnt++;
            end
            if (q.size() == 0) begin
               chk("unexpected_we", we, 0);
            end else begin
               pix_t e;
               e = q.pop_front();
               chk("pix_x", x_pos, e.x);
               chk("pix_y", y_pos, e.y);
               chk("pix_data", data_in, e.v);
               if (e.last) armed = 1;
            end
         end
         if (s_valid && s_ready) begin
            for (int b = 7; b >= 0; b--) begin
               if (pix_count < NPIX) begin
                  q.push_back('{pix_count % W, pix_count / W, s_data[b], pix_count == NPIX - 1});
                  pix_count++;
               end
            end
         end
      end
   end

   // Offer n bytes; vpct = chance of presenting a byte, spct = chance of a vsync_tick
   task automatic send_bytes(input int n, input int vpct, input int spct,
                             input bit fix, input logic [7:0] fval);
      int sent = 0;
      int budget = 0;
      bit hs;
      while (sent < n && budget < 40 * n + 100) begin
         @(negedge clk);
         hs = s_valid && s_ready;
         @(posedge clk);
         #1;
         budget++;
         if (hs) sent++;
         vsync_tick = ($urandom_range(0, 99) < spct);
         if (!s_valid || hs) begin
            if (sent < n && $urandom_range(0, 99) < vpct) begin
               s_valid = 1'b1;
               s_data  = fix ? fval : 8'($urandom);
            end else begin
               s_valid = 1'b0;
            end
         end
      end
      chk("bytes_accepted", sent, n);
      s_valid    = 1'b0;
      vsync_tick = 1'b0;
   endtask

   task automatic send_frame_rest(input int vpct, input int spct);
      send_bytes((NPIX - pix_count + 7) / 8, vpct, spct, 1'b0, 8'h00);
   endtask

   // Wait for the frame to complete, then pulse vsync_tick once
   task automatic do_swap();
      int t = 0;
      while (!armed && t < 50) begin
         @(posedge clk);
         t++;
      end
      chk("frame_complete_before_swap", armed, 1);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 vsync_tick = 1'b1;
      @(posedge clk);
      #1 vsync_tick = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_data     = 8'h00;
      s_valid    = 1'b0;
      vsync_tick = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      chk("rst_we", we, 0);
      chk("rst_x", x_pos, 0);
      chk("rst_y", y_pos, 0);
      chk("rst_data", data_in, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_disp", disp_bank, 0);
      chk("rst_bank", bank_counter, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_release", s_ready, 1);

      // single byte A5: eight contiguous writes at (0..7,0)
      track = 1; we_cnt = 0;
      send_bytes(1, 100, 0, 1'b1, 8'hA5);
      repeat (10) @(posedge clk);
      track = 0;
      chk("a5_we_cycles", we_cnt, 8);
      chk("a5_we_span", last_cyc - first_cyc + 1, 8);

      // sustained stream crossing the row wrap, no gap in we
      track = 1; we_cnt = 0;
      send_bytes(30, 100, 0, 1'b0, 8'h00);
      repeat (10) @(posedge clk);
      track = 0;
      chk("burst_we_cycles", we_cnt, 240);
      chk("burst_we_span", last_cyc - first_cyc + 1, 240);

      // rest of frame with gaps and stray vsync ticks, then the first swap
      send_frame_rest(60, 10);
      repeat (12) @(posedge clk);
      chk("hold_disp", disp_bank, 0);
      chk("hold_bank", bank_counter, 1);
      do_swap();
      chk("swap1_disp", disp_bank, 1);
      chk("swap1_bank", bank_counter, 2);
      chk("swap1_x", x_pos, 0);
      chk("swap1_y", y_pos, 0);

      // sixteen more frames: bank wraps through 15 -> 0
      for (int f = 0; f < 16; f++) begin
         send_frame_rest(70, 5);
         do_swap();
      end
      chk("swap17_disp", disp_bank, 1);
      chk("swap17_bank", bank_counter, 2);

      // vsync_tick on the very cycle the final pixel is written
      send_frame_rest(100, 0);
      repeat ((NPIX - 1) % 8) @(posedge clk);
      #1 vsync_tick = 1'b1;
      @(negedge clk);
      chk("coincident_we", we, 1);
      chk("coincident_x", x_pos, W - 1);
      chk("coincident_y", y_pos, H - 1);
      @(posedge clk);
      #1 vsync_tick = 1'b0;
      repeat (5) @(posedge clk);
      chk("coincident_no_swap_disp", disp_bank, 1);
      chk("coincident_no_swap_fd", frame_done, 0);
      do_swap();
      chk("swap18_disp", disp_bank, 2);
      chk("swap18_bank", bank_counter, 3);

      // asynchronous reset while shifting
      send_bytes(3, 100, 0, 1'b0, 8'h00);
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_we", we, 0);
      chk("mid_rst_x", x_pos, 0);
      chk("mid_rst_y", y_pos, 0);
      chk("mid_rst_data", data_in, 0);
      chk("mid_rst_ready", s_ready, 0);
      chk("mid_rst_disp", disp_bank, 0);
      chk("mid_rst_bank", bank_counter, 1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_mid_rst", s_ready, 1);
      track = 1; we_cnt = 0;
      send_bytes(1, 100, 0, 1'b1, 8'h3C);
      repeat (10) @(posedge clk);
      track = 0;
      chk("post_rst_we_cycles", we_cnt, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
